// File: rtl/morra_sequencer.sv
// Player-side self-play driver for the morra cinese judge.
// Opens a match, issues one legal move pair per manche, tallies verdicts.
module morra_sequencer #(
  parameter logic [7:0]  SEED_P1 = 8'hA5,
  parameter logic [7:0]  SEED_P2 = 8'h3C,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [3:0] n_manche_i,
  input  logic [1:0] manche_i,
  input  logic [1:0] partita_i,
  output logic       inizia_o,
  output logic [1:0] primo_o,
  output logic [1:0] secondo_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [1:0] result_o,
  output logic       timeout_err_o,
  output logic [4:0] wins1_o,
  output logic [4:0] wins2_o,
  output logic [4:0] draws_o,
  output logic [4:0] invalids_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, DRIVE, SAMPLE, FINISH
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    nm_q, nm_d;
  logic [4:0]    rem_q, rem_d;
  logic [4:0]    w1_q, w1_d, w2_q, w2_d;
  logic [4:0]    dr_q, dr_d, inv_q, inv_d;
  logic [1:0]    last1_q, last1_d;
  logic [1:0]    last2_q, last2_d;
  logic [7:0]    lfsr1_q, lfsr2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [1:0]    res_q, res_d;
  logic          terr_q, terr_d;
  logic [1:0]    mv1, mv2;

  function automatic logic [7:0] lfsr_nx(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Never 00, never the player's previous move.
  function automatic logic [1:0] pick(input logic [1:0] raw,
                                      input logic [1:0] last);
    logic [1:0] c;
    c = (raw == 2'b00) ? 2'b01 : raw;
    if (c == last) c = (c == 2'b11) ? 2'b01 : c + 2'b01;
    return c;
  endfunction

  function automatic logic [4:0] inc5(input logic [4:0] x);
    return (x == 5'd31) ? x : x + 5'd1;
  endfunction

  assign mv1 = pick(lfsr1_q[1:0], last1_q);
  assign mv2 = pick(lfsr2_q[1:0], last2_q);

  always_comb begin
    state_d   = state_q;
    nm_d      = nm_q;
    rem_d     = rem_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    dr_d      = dr_q;
    inv_d     = inv_q;
    last1_d   = last1_q;
    last2_d   = last2_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    res_d     = res_q;
    terr_d    = terr_q;
    inizia_o  = 1'b0;
    primo_o   = 2'b00;
    secondo_o = 2'b00;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          nm_d    = n_manche_i;
          rem_d   = {1'b0, n_manche_i} + 5'd4;
          w1_d    = '0;
          w2_d    = '0;
          dr_d    = '0;
          inv_d   = '0;
          res_d   = 2'b00;
          terr_d  = 1'b0;
          last1_d = 2'b00;
          last2_d = 2'b00;
          state_d = SETUP;
        end
      end
      SETUP: begin
        inizia_o             = 1'b1;
        {primo_o, secondo_o} = nm_q;
        state_d              = DRIVE;
      end
      DRIVE: begin
        primo_o   = mv1;
        secondo_o = mv2;
        last1_d   = mv1;
        last2_d   = mv2;
        state_d   = SAMPLE;
      end
      SAMPLE: begin
        unique case (manche_i)
          2'b01: w1_d  = inc5(w1_q);
          2'b10: w2_d  = inc5(w2_q);
          2'b11: dr_d  = inc5(dr_q);
          2'b00: inv_d = inc5(inv_q);
        endcase
        rem_d = rem_q - 5'd1;
        if (rem_q == 5'd1) begin
          cnt_d   = '0;
          state_d = FINISH;
        end else begin
          state_d = DRIVE;
        end
      end
      FINISH: begin
        cnt_d = cnt_q + 1'b1;
        if (partita_i != 2'b00) begin
          res_d   = partita_i;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          res_d   = 2'b00;
          terr_d  = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      nm_q    <= '0;
      rem_q   <= '0;
      w1_q    <= '0;
      w2_q    <= '0;
      dr_q    <= '0;
      inv_q   <= '0;
      last1_q <= '0;
      last2_q <= '0;
      lfsr1_q <= SEED_P1;
      lfsr2_q <= SEED_P2;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nm_q    <= nm_d;
      rem_q   <= rem_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      dr_q    <= dr_d;
      inv_q   <= inv_d;
      last1_q <= last1_d;
      last2_q <= last2_d;
      lfsr1_q <= lfsr_nx(lfsr1_q);
      lfsr2_q <= lfsr_nx(lfsr2_q);
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
      terr_q  <= terr_d;
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;
  assign result_o      = res_q;
  assign timeout_err_o = terr_q;
  assign wins1_o       = w1_q;
  assign wins2_o       = w2_q;
  assign draws_o       = dr_q;
  assign invalids_o    = inv_q;

endmodule
